// File: rtl/xreg_writeback.sv
// Scalar register-file write-port driver: round-robin arbitration between ALU and vector-unit
// results, one registered write per cycle, and a pending-destination scoreboard for hazard checks.
module xreg_writeback #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            src0Valid,
    input  logic [4:0]      src0Rd,
    input  logic [XLEN-1:0] src0Data,
    output logic            src0Ready,
    input  logic            src1Valid,
    input  logic [4:0]      src1Rd,
    input  logic [XLEN-1:0] src1Data,
    output logic            src1Ready,
    input  logic            issueValid,
    input  logic [4:0]      issueRd,
    output logic            issueReady,
    input  logic [4:0]      rs1Addr,
    input  logic [4:0]      rs2Addr,
    output logic            rs1Busy,
    output logic            rs2Busy,
    output logic [4:0]      writeAddr,
    output logic            writeEnable,
    output logic [XLEN-1:0] writeData,
    output logic            idle
);

    // lastGrantQ = 1 means src1 won the most recent transfer; reset value makes src0 go first.
    logic            lastGrantQ, lastGrantD;
    logic            grant1;
    logic            xfer;
    logic [4:0]      selRd;
    logic [XLEN-1:0] selData;
    logic [31:0]     pendingQ, pendingD;
    logic            writeEnableQ;
    logic [4:0]      writeAddrQ;
    logic [XLEN-1:0] writeDataQ;

    always_comb begin
        grant1     = src1Valid && (!src0Valid || !lastGrantQ);
        src1Ready  = grant1;
        src0Ready  = src0Valid && !grant1;
        xfer       = src0Valid || src1Valid;
        selRd      = grant1 ? src1Rd : src0Rd;
        selData    = grant1 ? src1Data : src0Data;
        lastGrantD = xfer ? grant1 : lastGrantQ;
    end

    always_comb begin
        issueReady = !pendingQ[issueRd] || (issueRd == 5'd0);
        rs1Busy    = pendingQ[rs1Addr];
        rs2Busy    = pendingQ[rs2Addr];
        idle       = (pendingQ == 32'd0) && !writeEnableQ;
    end

    // Set is applied after clear so a same-cycle set/clear of one register leaves it pending.
    always_comb begin
        pendingD = pendingQ;
        if (writeEnableQ && (writeAddrQ != 5'd0)) begin
            pendingD[writeAddrQ] = 1'b0;
        end
        if (issueValid && issueReady && (issueRd != 5'd0)) begin
            pendingD[issueRd] = 1'b1;
        end
        pendingD[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrantQ   <= 1'b1;
            pendingQ     <= 32'd0;
            writeEnableQ <= 1'b0;
            writeAddrQ   <= 5'd0;
            writeDataQ   <= '0;
        end else begin
            lastGrantQ   <= lastGrantD;
            pendingQ     <= pendingD;
            writeEnableQ <= xfer && (selRd != 5'd0);
            // Results for x0 are consumed but leave the write address/data untouched.
            if (xfer && (selRd != 5'd0)) begin
                writeAddrQ <= selRd;
                writeDataQ <= selData;
            end
        end
    end

    assign writeEnable = writeEnableQ;
    assign writeAddr   = writeAddrQ;
    assign writeData   = writeDataQ;

endmodule

// File: tb/tb_xreg_writeback.sv
// Bench for xreg_writeback: directed scenarios plus randomized traffic, with a queue-based
// scoreboard of expected register-file writes checked by an independent monitor.
module tb_xreg_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        src0Valid = 1'b0, src1Valid = 1'b0, issueValid = 1'b0;
    logic [4:0]  src0Rd = '0, src1Rd = '0, issueRd = '0, rs1Addr = '0, rs2Addr = '0;
    logic [31:0] src0Data = '0, src1Data = '0;
    logic        src0Ready, src1Ready, issueReady, rs1Busy, rs2Busy, writeEnable, idle;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;

    int total = 0;
    int bad = 0;

    // Reference model state.
    logic [36:0] expQ[$];
    logic [31:0] pend = '0;
    logic [4:0]  wrCur = '0;
    logic [4:0]  nextWr = '0;
    logic        issAcc = 1'b0;
    logic [4:0]  issRdS = '0;
    logic        lastWasSrc1 = 1'b1;

    xreg_writeback #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .src0Valid(src0Valid), .src0Rd(src0Rd), .src0Data(src0Data), .src0Ready(src0Ready),
        .src1Valid(src1Valid), .src1Rd(src1Rd), .src1Data(src1Data), .src1Ready(src1Ready),
        .issueValid(issueValid), .issueRd(issueRd), .issueReady(issueReady),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Busy(rs1Busy), .rs2Busy(rs2Busy),
        .writeAddr(writeAddr), .writeEnable(writeEnable), .writeData(writeData), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && writeEnable) begin
            if (expQ.size() == 0) begin
                chk("unexpected_write_addr", 64'(writeAddr), 64'hFFFF);
            end else begin
                logic [36:0] e;
                e = expQ.pop_front();
                chk("write_addr", 64'(writeAddr), 64'(e[36:32]));
                chk("write_data", 64'(writeData), 64'(e[31:0]));
            end
        end
    end

    task automatic modelReset();
        pend = '0;
        wrCur = '0;
        nextWr = '0;
        issAcc = 1'b0;
        lastWasSrc1 = 1'b1;
        expQ.delete();
    endtask

    task automatic clearInputs();
        src0Valid = 1'b0; src1Valid = 1'b0; issueValid = 1'b0;
        src0Rd = '0; src1Rd = '0; issueRd = '0; rs1Addr = '0; rs2Addr = '0;
        src0Data = '0; src1Data = '0;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        clearInputs();
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: advance the model across the edge, drive inputs, check combinational outputs.
    task automatic doCycle(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                           input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                           input logic iv, input logic [4:0] ir,
                           input logic [4:0] a1, input logic [4:0] a2,
                           output logic g0, output logic g1);
        logic       expIr;
        logic [4:0] xrd;
        logic [31:0] xd;
        @(posedge clk);
        #1;
        if (wrCur != 5'd0) pend[wrCur] = 1'b0;
        if (issAcc) pend[issRdS] = 1'b1;
        wrCur = nextWr;
        src0Valid = v0; src0Rd = r0; src0Data = d0;
        src1Valid = v1; src1Rd = r1; src1Data = d1;
        issueValid = iv; issueRd = ir; rs1Addr = a1; rs2Addr = a2;
        #1;
        if (v0 && v1) g1 = !lastWasSrc1;
        else g1 = v1;
        g0 = v0 && !g1;
        expIr = (ir == 5'd0) || !pend[ir];
        chk("src0Ready", 64'(src0Ready), 64'(g0));
        chk("src1Ready", 64'(src1Ready), 64'(g1));
        chk("issueReady", 64'(issueReady), 64'(expIr));
        chk("rs1Busy", 64'(rs1Busy), 64'(pend[a1]));
        chk("rs2Busy", 64'(rs2Busy), 64'(pend[a2]));
        chk("idle", 64'(idle), 64'((pend == 32'd0) && (wrCur == 5'd0)));
        xrd = g1 ? r1 : r0;
        xd  = g1 ? d1 : d0;
        if (g0 || g1) lastWasSrc1 = g1;
        nextWr = ((g0 || g1) && xrd != 5'd0) ? xrd : 5'd0;
        if (nextWr != 5'd0) expQ.push_back({xrd, xd});
        issAcc = iv && expIr && (ir != 5'd0);
        issRdS = ir;
    endtask

    logic g0, g1;
    logic h0v = 1'b0, h1v = 1'b0;
    logic [4:0] h0rd = '0, h1rd = '0;
    logic [31:0] h0d = '0, h1d = '0;

    initial begin
        #3;
        chk("reset_writeEnable", 64'(writeEnable), 64'd0);
        chk("reset_writeAddr", 64'(writeAddr), 64'd0);
        chk("reset_writeData", 64'(writeData), 64'd0);
        chk("reset_idle", 64'(idle), 64'd1);
        resetDut();

        // Single ALU result.
        doCycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        doCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Both sources contending: writes must come out 1, 3, 2, 4.
        resetDut();
        doCycle(1, 1, 32'h11, 1, 3, 32'h33, 0, 0, 0, 0, g0, g1);
        doCycle(1, 2, 32'h22, 1, 3, 32'h33, 0, 0, 0, 0, g0, g1);
        doCycle(1, 2, 32'h22, 1, 4, 32'h44, 0, 0, 0, 0, g0, g1);
        doCycle(0, 0, 0, 1, 4, 32'h44, 0, 0, 0, 0, g0, g1);
        doCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Scoreboard set/clear around rd=7.
        doCycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, g0, g1);
        doCycle(0, 0, 0, 0, 0, 0, 0, 7, 7, 7, g0, g1);
        doCycle(0, 0, 0, 1, 7, 32'h7777, 0, 7, 7, 0, g0, g1);
        doCycle(0, 0, 0, 0, 0, 0, 0, 7, 7, 0, g0, g1);
        doCycle(0, 0, 0, 0, 0, 0, 0, 7, 7, 0, g0, g1);

        // x0 result and x0 issue leave the scoreboard alone.
        doCycle(1, 0, 32'h12345678, 0, 0, 0, 1, 0, 0, 0, g0, g1);
        doCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        doCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // src1 held while src0 wins once.
        resetDut();
        doCycle(1, 21, 32'hA21, 1, 20, 32'hB20, 0, 0, 0, 0, g0, g1);
        doCycle(1, 22, 32'hA22, 1, 20, 32'hB20, 0, 0, 0, 0, g0, g1);
        doCycle(1, 22, 32'hA22, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        doCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Asynchronous reset in the middle of activity.
        doCycle(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, g0, g1);
        doCycle(1, 11, 32'hB11, 0, 0, 0, 1, 9, 3, 0, g0, g1);
        doCycle(1, 12, 32'hC12, 0, 0, 0, 0, 0, 3, 9, g0, g1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_writeEnable", 64'(writeEnable), 64'd0);
        chk("async_rst_idle", 64'(idle), 64'd1);
        chk("async_rst_rs1Busy", 64'(rs1Busy), 64'd0);
        chk("async_rst_rs2Busy", 64'(rs2Busy), 64'd0);
        resetDut();

        // Randomized traffic; sources hold their item until accepted.
        for (int c = 0; c < 400; c++) begin
            if (!h0v && $urandom_range(0, 2) != 0) begin
                h0v = 1'b1; h0rd = 5'($urandom_range(0, 15)); h0d = $urandom;
            end
            if (!h1v && $urandom_range(0, 2) != 0) begin
                h1v = 1'b1; h1rd = 5'($urandom_range(0, 15)); h1d = $urandom;
            end
            doCycle(h0v, h0rd, h0d, h1v, h1rd, h1d, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                    5'($urandom_range(0, 15)), g0, g1);
            if (g0) h0v = 1'b0;
            if (g1) h1v = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            doCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        end
        chk("writes_drained", 64'(expQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
